e_mdu: RTL
==========

# e_mdu

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It sits beside the ALU and feeds the E→M pipeline register: mfhi/mflo results leave on `E_MDU_Result`, which the stage muxes into the ALU-result path. It owns HI/LO and models multi-cycle latency with a busy counter. The hazard unit stalls any MD-class instruction in D while `E_MDU_Start | E_MDU_Busy` is high.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports (synchronous, active-high reset; single clock):
- Clk  input  1  pipeline clock, all state on posedge
- Reset  input  1  synchronous active-high reset
- E_MDU_Op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 treated as none
- E_MDU_A  input  32  forwarded rs value
- E_MDU_B  input  32  forwarded rt value
- E_MDU_Start  output  1  combinational: Op ∈ {1..4} and not Busy
- E_MDU_Busy  output  1  registered: operation in flight
- E_MDU_Result  output  32  combinational: HI if Op=7, LO if Op=8, else 0
- E_MDU_HI  output  32  architectural HI (debug/verification)
- E_MDU_LO  output  32  architectural LO

## Operation
- Idle with Start: latch the computed result into pending HI/LO, load the counter with MULT_CYCLES or DIV_CYCLES, and assert Busy.
- Busy: decrement the counter each cycle. On the edge where the counter goes 1→0, write pending into HI/LO and deassert Busy.
- mult: signed 64-bit product, HI = [63:32], LO = [31:0]. multu: unsigned.
- div: quotient truncates toward zero → LO; remainder takes the sign of the dividend → HI. divu: unsigned.
- Special case: 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (div/divu, B=0): Busy runs the full DIV_CYCLES, and HI/LO are unchanged at completion.
- mthi/mtlo when idle: HI/LO ← A on the next edge, no Busy.
- Any Op 1–6 while Busy is ignored. The hazard unit guarantees this never happens; the ignore is a safety net, and the bench checks it.
- mfhi/mflo read the current HI/LO combinationally and never wait on Busy. The stall is the hazard unit's job.
- Reset, including mid-operation: HI=LO=0, pending=0, counter=0, Busy=0. The in-flight result is discarded.
- Outputs after reset: Busy 0, HI 0, LO 0. Start and Result follow their inputs.

## Timing
- Start sampled at the edge ending cycle t → Busy high in cycles t+1 … t+N.
- HI/LO hold the new value from cycle t+N+1, when Busy is low.
- mfhi issued in cycle t+N+1 returns the new value in that same cycle.
- Minimum spacing between mult/div starts is N+1 cycles. Back-to-back issue is legal in cycle t+N+1.
- mthi/mtlo take effect in the cycle after issue. A mfhi in the next cycle sees the new value.
- Reset and Start in the same cycle: Reset wins, and Busy stays 0.
- Stall/flush of E by the hazard unit does not cancel an accepted operation. The E register bubbles Op to 0.

## Structure
- Shared package `mdu_pkg`:
  - MDU_OP_* encodings (4-bit)
  - default MULT_CYCLES/DIV_CYCLES constants
  - helper predicate "is MD op" (Op 1–8), used by both `e_mdu` and the hazard unit
- Single module with no sub-module. Arithmetic is behavioural `*` `/` `%` with `$signed` casts, computed into pending registers at Start.

## Test plan
- mult A=0xFFFFFFFF, B=2: Busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat as multu: HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2: Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2: LO=3, HI=1. Div A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- Preload HI=0x11, LO=0x22, then div by B=0: Busy 10 cycles, then HI=0x11, LO=0x22.
- mthi A=0x1234, then mfhi next cycle → Result=0x1234. During a mult, issue mthi A=0xDEAD: ignored, and HI ends as the product.
- Start mult, assert Reset in busy cycle 3: next cycle Busy=0, HI=LO=0, and no late write after 5 cycles.
- Start mult, then mfhi in busy cycle 2: Result shows the old HI. mfhi at t+N+1: Result shows the new HI. A second mult at t+N+1 raises Start=1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit and the hazard unit.
// Holds the op encodings, the default latencies and the MD-class predicate.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_OP_NONE  = 4'd0,
    MDU_OP_MULT  = 4'd1,
    MDU_OP_MULTU = 4'd2,
    MDU_OP_DIV   = 4'd3,
    MDU_OP_DIVU  = 4'd4,
    MDU_OP_MTHI  = 4'd5,
    MDU_OP_MTLO  = 4'd6,
    MDU_OP_MFHI  = 4'd7,
    MDU_OP_MFLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  // True for every op the hazard unit must hold in D while the MDU is occupied.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO and models mult/div latency
// with a busy counter; mfhi/mflo read HI/LO combinationally.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  E_MDU_Op,
  input  logic [31:0] E_MDU_A,
  input  logic [31:0] E_MDU_B,
  output logic        E_MDU_Start,
  output logic        E_MDU_Busy,
  output logic [31:0] E_MDU_Result,
  output logic [31:0] E_MDU_HI,
  output logic [31:0] E_MDU_LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic signed [63:0] smul;
  logic [63:0]        umul;
  logic [31:0]        sdiv_b, udiv_b;
  logic signed [31:0] squot, srem;
  logic [31:0]        uquot, urem;
  logic               div_by_zero;

  assign smul = $signed({{32{E_MDU_A[31]}}, E_MDU_A}) * $signed({{32{E_MDU_B[31]}}, E_MDU_B});
  assign umul = {32'h0, E_MDU_A} * {32'h0, E_MDU_B};

  // A divisor of 1 sidesteps both divide-by-zero and the INT_MIN / -1 overflow;
  // for the latter, quotient = dividend and remainder = 0 is exactly the required result.
  assign div_by_zero = (E_MDU_B == 32'h0);
  assign sdiv_b = (div_by_zero || (E_MDU_A == 32'h8000_0000 && E_MDU_B == 32'hFFFF_FFFF))
                  ? 32'd1 : E_MDU_B;
  assign udiv_b = div_by_zero ? 32'd1 : E_MDU_B;
  assign squot  = $signed(E_MDU_A) / $signed(sdiv_b);
  assign srem   = $signed(E_MDU_A) % $signed(sdiv_b);
  assign uquot  = E_MDU_A / udiv_b;
  assign urem   = E_MDU_A % udiv_b;

  assign E_MDU_Start = is_md_op(E_MDU_Op) && (E_MDU_Op <= MDU_OP_DIVU) && !busy_q;
  assign E_MDU_Busy  = busy_q;
  assign E_MDU_HI    = hi_q;
  assign E_MDU_LO    = lo_q;

  always_comb begin
    E_MDU_Result = 32'h0;
    if (E_MDU_Op == MDU_OP_MFHI)      E_MDU_Result = hi_q;
    else if (E_MDU_Op == MDU_OP_MFLO) E_MDU_Result = lo_q;
  end

  // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;

    if (E_MDU_Start) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(DIV_CYCLES);
      case (E_MDU_Op)
        MDU_OP_MULT: begin
          {pend_hi_d, pend_lo_d} = smul;
          cnt_d = CNT_W'(MULT_CYCLES);
        end
        MDU_OP_MULTU: begin
          {pend_hi_d, pend_lo_d} = umul;
          cnt_d = CNT_W'(MULT_CYCLES);
        end
        // Divide by zero replays the current HI/LO so completion leaves them untouched.
        MDU_OP_DIV: begin
          pend_hi_d = div_by_zero ? hi_q : srem;
          pend_lo_d = div_by_zero ? lo_q : squot;
        end
        MDU_OP_DIVU: begin
          pend_hi_d = div_by_zero ? hi_q : urem;
          pend_lo_d = div_by_zero ? lo_q : uquot;
        end
        default: ;
      endcase
    end else if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        hi_d   = pend_hi_q;
        lo_d   = pend_lo_q;
      end
    end else if (E_MDU_Op == MDU_OP_MTHI) begin
      hi_d = E_MDU_A;
    end else if (E_MDU_Op == MDU_OP_MTLO) begin
      lo_d = E_MDU_A;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
      pend_hi_q <= 32'h0;
      pend_lo_q <= 32'h0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

endmodule
